// File: rtl/imem_pkg.sv
// Shared types for the loadable instruction memory: fetch fault codes and load/run states.
package imem_pkg;

   typedef enum logic [1:0] {
      FLT_OK       = 2'b00,
      FLT_MISALIGN = 2'b01,
      FLT_RANGE    = 2'b10,
      FLT_UNLOADED = 2'b11
   } fault_e;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port, one registered read port, contents survive reset.
// Read data appears one cycle after rd_en and holds until the next enabled read.
module imem_array #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32,
   parameter int IDX_W  = 5
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: program streamed in while in LOAD, byte-addressed fetch in RUN.
// Fetch latency 1 cycle through a 1-entry output register; req_ready drops while a response is stalled.
module instr_mem_loadable
   import imem_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load_start,
   input  logic                       ld_valid,
   input  logic [DATA_W-1:0]          ld_data,
   input  logic                       load_done,
   output logic                       ld_overflow,
   output logic [$clog2(DEPTH+1)-1:0] prog_len,
   output logic                       running,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [ADDR_W-1:0]          req_addr,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_W-1:0]          rsp_data,
   output logic [1:0]                 rsp_fault
);

   localparam int LSB_W = $clog2(DATA_W/8);
   localparam int LEN_W = $clog2(DEPTH+1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((1 << LSB_W) - 1);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  ld_ptr;
   fault_e            fault_q, req_fault;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en, rd_en, accept;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_LOAD;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (load_done)  state_d = ST_RUN;
         ST_RUN:  if (load_start) state_d = ST_LOAD;
      endcase
   end

   assign running = (state_q == ST_RUN);
   assign wr_en   = !running && ld_valid && (ld_ptr != LEN_W'(DEPTH));

   // ld_ptr doubles as the program length: both advance on every stored word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_ptr      <= '0;
         ld_overflow <= 1'b0;
      end else if (running) begin
         if (load_start) begin
            ld_ptr      <= '0;
            ld_overflow <= 1'b0;
         end
      end else if (ld_valid) begin
         if (wr_en) ld_ptr <= ld_ptr + 1'b1;
         else       ld_overflow <= 1'b1;
      end
   end

   assign prog_len  = ld_ptr;
   assign req_ready = running && (!rsp_valid || rsp_ready);
   assign accept    = req_valid && req_ready;
   assign idx       = req_addr >> LSB_W;

   always_comb begin
      req_fault = FLT_OK;
      if ((req_addr & LSB_MASK) != '0)      req_fault = FLT_MISALIGN;
      else if (idx >= ADDR_W'(DEPTH))       req_fault = FLT_RANGE;
      else if (idx >= ADDR_W'(ld_ptr))      req_fault = FLT_UNLOADED;
   end

   // the array is only read for in-range addresses; faulted responses mask its stale output
   assign rd_en = accept && (req_fault == FLT_OK);

   imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (ld_ptr[IDX_W-1:0]),
      .wr_data (ld_data),
      .rd_en   (rd_en),
      .rd_addr (idx[IDX_W-1:0]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         fault_q   <= FLT_OK;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         fault_q   <= req_fault;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   assign rsp_fault = fault_q;
   assign rsp_data  = (rsp_valid && fault_q == FLT_OK) ? rd_data : '0;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: load, fetch, faults, backpressure, overflow, reload, reset.
module tb_instr_mem_loadable;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 16;

   logic              clk, reset;
   logic              load_start, ld_valid, load_done;
   logic [DATA_W-1:0] ld_data;
   logic              ld_overflow, running;
   logic [5:0]        prog_len;
   logic              req_valid, req_ready, rsp_valid, rsp_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] rsp_data;
   logic [1:0]        rsp_fault;

   int errors = 0;
   int checks = 0;

   instr_mem_loadable #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data), .load_done(load_done),
      .ld_overflow(ld_overflow), .prog_len(prog_len), .running(running),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      load_start = 0; ld_valid = 0; ld_data = '0; load_done = 0;
      req_valid = 0; req_addr = '0; rsp_ready = 1;
      reset = 0;
      tick();
      tick();
      @(negedge clk);
      reset = 1;
      tick();
   endtask

   task automatic load_word(input logic [15:0] d);
      ld_valid = 1; ld_data = d;
      tick();
      ld_valid = 0;
   endtask

   task automatic pulse_done();
      load_done = 1;
      tick();
      load_done = 0;
   endtask

   task automatic pulse_start();
      load_start = 1;
      tick();
      load_start = 0;
   endtask

   // single fetch with rsp_ready held high; v reports whether a response appeared
   task automatic fetch_one(input logic [15:0] a, output logic v,
                            output logic [15:0] d, output logic [1:0] f);
      int n;
      req_valid = 1; req_addr = a; rsp_ready = 1;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 0;
      @(negedge clk);
      v = rsp_valid; d = rsp_data; f = rsp_fault;
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
      checks++; if (prog_len !== 6'd0) begin errors++; $display("FAIL reset_prog_len got=%0d exp=0", prog_len); end
      checks++; if ({ld_overflow, req_ready, rsp_fault, rsp_data} !== 20'h0) begin
         errors++; $display("FAIL reset_misc got ovf=%b rdy=%b flt=%b data=%h exp all 0", ld_overflow, req_ready, rsp_fault, rsp_data);
      end
      tick();
   endtask

   task automatic test_load_fetch();
      logic [15:0] exp_d [3];
      exp_d[0] = 16'h0120; exp_d[1] = 16'h0121; exp_d[2] = 16'h0AE2;
      for (int i = 0; i < 3; i++) load_word(exp_d[i]);
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_req_ready got=%b exp=0", req_ready); end
      tick();
      pulse_done();
      checks++; if (running !== 1'b1 || prog_len !== 6'd3) begin
         errors++; $display("FAIL run_entry got running=%b prog_len=%0d exp 1/3", running, prog_len);
      end
      rsp_ready = 1; req_valid = 1; req_addr = 16'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i < 2) req_addr = 16'(2 * (i + 1));
         else req_valid = 0;
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d[i] || rsp_fault !== 2'b00) begin
            errors++; $display("FAIL b2b_word%0d got v=%b d=%h f=%b exp v=1 d=%h f=00", i, rsp_valid, rsp_data, rsp_fault, exp_d[i]);
         end
      end
      tick();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got=%b exp=0", rsp_valid); end
      tick();
   endtask

   task automatic test_faults();
      logic v; logic [15:0] d; logic [1:0] f;
      logic [15:0] addrs [5];
      logic [1:0]  exp_f [5];
      logic [15:0] exp_d [5];
      addrs[0] = 16'd3;  exp_f[0] = 2'b01; exp_d[0] = 16'h0000;
      addrs[1] = 16'd64; exp_f[1] = 2'b10; exp_d[1] = 16'h0000;
      addrs[2] = 16'd6;  exp_f[2] = 2'b11; exp_d[2] = 16'h0000;
      addrs[3] = 16'd65; exp_f[3] = 2'b01; exp_d[3] = 16'h0000;
      addrs[4] = 16'd4;  exp_f[4] = 2'b00; exp_d[4] = 16'h0AE2;
      for (int i = 0; i < 5; i++) begin
         fetch_one(addrs[i], v, d, f);
         checks++; if (v !== 1'b1 || f !== exp_f[i] || d !== exp_d[i]) begin
            errors++; $display("FAIL fault_addr%0d got v=%b d=%h f=%b exp v=1 d=%h f=%b", addrs[i], v, d, f, exp_d[i], exp_f[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      req_valid = 1; req_addr = 16'd2; rsp_ready = 0;
      tick();
      req_addr = 16'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 16'h0121 || rsp_fault !== 2'b00) begin
            errors++; $display("FAIL stall_cyc%0d got rdy=%b v=%b d=%h f=%b exp 0/1/0121/00", i, req_ready, rsp_valid, rsp_data, rsp_fault);
         end
         tick();
      end
      rsp_ready = 1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", req_ready); end
      tick();
      req_valid = 0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0AE2) begin
         errors++; $display("FAIL release_next got v=%b d=%h exp 1/0ae2", rsp_valid, rsp_data);
      end
      tick();
   endtask

   task automatic test_overflow();
      logic v; logic [15:0] d; logic [1:0] f;
      pulse_start();
      @(negedge clk);
      checks++; if (running !== 1'b0 || prog_len !== 6'd0) begin
         errors++; $display("FAIL reload_entry got running=%b prog_len=%0d exp 0/0", running, prog_len);
      end
      tick();
      for (int i = 0; i < DEPTH + 2; i++) load_word(16'h1000 + 16'(i));
      @(negedge clk);
      checks++; if (ld_overflow !== 1'b1 || prog_len !== 6'd32) begin
         errors++; $display("FAIL overflow got ovf=%b prog_len=%0d exp 1/32", ld_overflow, prog_len);
      end
      tick();
      pulse_done();
      fetch_one(16'd62, v, d, f);
      checks++; if (v !== 1'b1 || d !== 16'h101F || f !== 2'b00) begin
         errors++; $display("FAIL last_word got v=%b d=%h f=%b exp 1/101f/00", v, d, f);
      end
      fetch_one(16'd0, v, d, f);
      checks++; if (d !== 16'h1000 || f !== 2'b00) begin
         errors++; $display("FAIL first_word got d=%h f=%b exp 1000/00", d, f);
      end
   endtask

   task automatic test_reload_pending();
      logic v; logic [15:0] d; logic [1:0] f;
      req_valid = 1; req_addr = 16'd2; rsp_ready = 0;
      tick();
      req_valid = 0;
      pulse_start();
      @(negedge clk);
      checks++; if (running !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 16'h1001) begin
         errors++; $display("FAIL pending_in_load got run=%b rdy=%b v=%b d=%h exp 0/0/1/1001", running, req_ready, rsp_valid, rsp_data);
      end
      checks++; if (ld_overflow !== 1'b0 || prog_len !== 6'd0) begin
         errors++; $display("FAIL load_clear got ovf=%b prog_len=%0d exp 0/0", ld_overflow, prog_len);
      end
      rsp_ready = 1;
      tick();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pending_consumed got=%b exp=0", rsp_valid); end
      tick();
      load_word(16'hEFFF);
      pulse_done();
      fetch_one(16'd0, v, d, f);
      checks++; if (v !== 1'b1 || d !== 16'hEFFF || f !== 2'b00) begin
         errors++; $display("FAIL reload_word got v=%b d=%h f=%b exp 1/efff/00", v, d, f);
      end
      fetch_one(16'd2, v, d, f);
      checks++; if (d !== 16'h0000 || f !== 2'b11) begin
         errors++; $display("FAIL reload_unloaded got d=%h f=%b exp 0000/11", d, f);
      end
   endtask

   task automatic test_reset_mid();
      logic v; logic [15:0] d; logic [1:0] f;
      req_valid = 1; req_addr = 16'd0; rsp_ready = 0;
      tick();
      req_valid = 0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", rsp_valid); end
      #1;
      reset = 0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || running !== 1'b0 || prog_len !== 6'd0 || rsp_data !== 16'h0) begin
         errors++; $display("FAIL mid_reset got v=%b run=%b len=%0d d=%h exp 0/0/0/0000", rsp_valid, running, prog_len, rsp_data);
      end
      @(negedge clk);
      reset = 1;
      rsp_ready = 1;
      tick();
      pulse_done();
      fetch_one(16'd0, v, d, f);
      checks++; if (v !== 1'b1 || d !== 16'h0000 || f !== 2'b11) begin
         errors++; $display("FAIL empty_prog got v=%b d=%h f=%b exp 1/0000/11", v, d, f);
      end
   endtask

   initial begin
      reset = 1;
      test_reset();
      test_load_fetch();
      test_faults();
      test_backpressure();
      test_overflow();
      test_reload_pending();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no completion exp finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
